fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, byte-address/PC width.
REQ-003 SHALL have parameter DEPTH, default 4, buffer entries (power of 2, >=2).
REQ-004 SHALL have parameter MEM_LAT, default 1, instruction-memory read latency in cycles (>=1).
REQ-005 SHALL have parameter PC_STEP, default 2, PC increment per sequential fetch.
REQ-006 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-007 Ports: clk  in  1  sole clock; all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 redirect_valid  in  1  flush and restart fetch (taken jump or misprediction from execute).
REQ-010 redirect_pc  in  ADDR_W  new fetch address, sampled when redirect_valid=1.
REQ-011 imem_raddr  out  ADDR_W  byte address presented to instruction memory.
REQ-012 imem_ren  out  1  fetch issued this cycle.
REQ-013 imem_rdata  in  DATA_W  read data, valid exactly MEM_LAT cycles after issue.
REQ-014 out_valid  out  1  head entry present.
REQ-015 out_instr  out  DATA_W  head instruction.
REQ-016 out_pc  out  ADDR_W  PC of head instruction.
REQ-017 out_ready  in  1  decode accepts head (stall when 0).
REQ-018 out_count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-019 imem_raddr SHALL equal internal fetch_pc; imem_ren=1 iff count + inflight < DEPTH and redirect_valid=0.
REQ-020 On issue, fetch_pc SHALL advance by PC_STEP (ADDR_W wrap-around, no saturation).
REQ-021 In-flight fetches SHALL be tracked by a MEM_LAT-stage shift register of {valid, pc}; stage MEM_LAT-1 valid pushes {pc, imem_rdata} into the buffer.
REQ-022 Credit rule (REQ-019) SHALL guarantee no push into a full buffer; a push while full SHALL never occur.
REQ-023 Pop occurs when out_valid & out_ready; push and pop in the same cycle SHALL leave count unchanged, including when full or empty-with-arriving-data.
REQ-024 Empty buffer: out_valid=0; out_instr/out_pc hold last values; data arriving SHALL appear at out_valid the cycle after arrival (no bypass).
REQ-025 Throughput with out_ready=1 constantly SHALL be one instruction per cycle once DEPTH >= MEM_LAT+1.
REQ-026 redirect_valid=1 SHALL, at that clock edge: empty the buffer, clear all in-flight valid bits, set fetch_pc=redirect_pc; no issue that cycle.
REQ-027 Redirect SHALL take priority over simultaneous push, pop and issue; a response arriving in the redirect cycle SHALL be discarded.
REQ-028 First issue after redirect SHALL be on the following cycle at redirect_pc.
REQ-029 Back-to-back redirects SHALL each restart; only the last redirect_pc is fetched.
REQ-030 Buffer order SHALL be strict FIFO; read/write pointers wrap modulo DEPTH.

Reset
REQ-031 While rst_n=0: fetch_pc=RESET_PC, count=0, pointers=0, in-flight valids=0, out_valid=0, imem_ren=0, out_instr=0, out_pc=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered and in-flight fetches immediately (asynchronously).
REQ-033 First issue SHALL occur on the first rising edge after rst_n deasserts, at RESET_PC.

Structure
REQ-034 Shared package fetch_pkg SHALL hold default DATA_W, ADDR_W, PC_STEP and RESET_PC constants used by the CPU top and this block.
REQ-035 Storage SHALL be one sub-module, sync_fifo (parameters WIDTH=DATA_W+ADDR_W, DEPTH; push, pop, flush, count); issue/credit logic stays in fetch_buffer.

Verification
REQ-036 Bench memory model: imem_rdata = imem_raddr XOR 16'hA5A5, delayed MEM_LAT cycles.
REQ-037 Streaming: defaults, out_ready=1 -> out_pc 0,2,4,6,... one per cycle from cycle 3, out_instr=16'hA5A5,16'hA5A7,...
REQ-038 Stall fill: out_ready=0 for 10 cycles -> out_count saturates at 4, imem_ren=0 while 4 credits used, no loss; release -> pcs 0,2,4,6,8 in order.
REQ-039 Redirect: after out_pc=6 popped, redirect_valid=1, redirect_pc=16'h0040 -> next out_pc=16'h0040, no 8/10 ever output, out_count=0 the cycle after redirect.
REQ-040 Redirect with simultaneous arriving response and pop -> response discarded, count=0, next issue at redirect_pc.
REQ-041 MEM_LAT=3, DEPTH=4, out_ready toggling 1/0 -> in-order delivery, never more than 4 entries+in-flight; rst_n pulsed low mid-stream -> out_valid=0 immediately, restart at 0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared fetch-path defaults used by the CPU top and blocks |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int C_DATA_W   = 16;
  localparam int C_ADDR_W   = 16;
  localparam int C_PC_STEP  = 2;
  localparam int C_RESET_PC = 0;

  // Occupancy counters must represent 0..DEPTH inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with flush, occupancy count, no bypass  |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_buffer : credit-based instruction prefetch queue with redirect  |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_W   = C_DATA_W,
  parameter int ADDR_W   = C_ADDR_W,
  parameter int DEPTH    = 4,
  parameter int MEM_LAT  = 1,
  parameter int PC_STEP  = C_PC_STEP,
  parameter int RESET_PC = C_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [ADDR_W-1:0]      imem_raddr,
  output logic                   imem_ren,
  input  logic [DATA_W-1:0]      imem_rdata,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_instr,
  output logic [ADDR_W-1:0]      out_pc,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] out_count
);

  localparam int CW = count_width(DEPTH);
  localparam int SW = CW + $clog2(MEM_LAT + 1) + 1;
  localparam int EW = DATA_W + ADDR_W;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [MEM_LAT-1:0] r_fl_vld;
  logic [ADDR_W-1:0]  r_fl_pc [MEM_LAT];
  logic [DATA_W-1:0]  r_hold_instr;
  logic [ADDR_W-1:0]  r_hold_pc;
  logic [SW-1:0]      w_used;
  logic               w_issue;
  logic               w_empty;
  logic [EW-1:0]      w_head;
  logic [CW-1:0]      w_count;

  // Credits cover both buffered entries and fetches still in the memory pipe.
  always_comb begin
    w_used = SW'(w_count);
    for (int i = 0; i < MEM_LAT; i++) w_used = w_used + SW'(r_fl_vld[i]);
  end

  assign w_issue    = rst_n & ~redirect_valid & (w_used < SW'(DEPTH));
  assign imem_ren   = w_issue;
  assign imem_raddr = r_fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= ADDR_W'(RESET_PC);
      r_fl_vld   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_fl_vld   <= '0;
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
      r_fl_vld[0] <= w_issue;
      for (int i = 1; i < MEM_LAT; i++) r_fl_vld[i] <= r_fl_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_fl_pc[0] <= r_fetch_pc;
    for (int i = 1; i < MEM_LAT; i++) r_fl_pc[i] <= r_fl_pc[i-1];
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_fl_vld[MEM_LAT-1]),
    .i_pop   (out_valid & out_ready),
    .i_flush (redirect_valid),
    .i_wdata ({r_fl_pc[MEM_LAT-1], imem_rdata}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // Remember the last head so the outputs stay stable while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else if (!w_empty) begin
      r_hold_pc    <= w_head[EW-1:DATA_W];
      r_hold_instr <= w_head[DATA_W-1:0];
    end
  end

  assign out_valid = ~w_empty;
  assign out_pc    = w_empty ? r_hold_pc    : w_head[EW-1:DATA_W];
  assign out_instr = w_empty ? r_hold_instr : w_head[DATA_W-1:0];
  assign out_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// Directed bench for fetch_buffer: MEM_LAT=1 vector table plus MEM_LAT=3 stream with reset pulse.
module tb_fetch_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (MEM_LAT=1, DEPTH=4)
  logic        rst_a, rv_a, ren_a, val_a, rdy_a;
  logic [15:0] rpc_a, raddr_a, rdata_a, instr_a, pc_a;
  logic [2:0]  cnt_a;

  fetch_buffer u_a (
    .clk(clk), .rst_n(rst_a), .redirect_valid(rv_a), .redirect_pc(rpc_a),
    .imem_raddr(raddr_a), .imem_ren(ren_a), .imem_rdata(rdata_a),
    .out_valid(val_a), .out_instr(instr_a), .out_pc(pc_a),
    .out_ready(rdy_a), .out_count(cnt_a)
  );

  always @(posedge clk) rdata_a <= raddr_a ^ 16'hA5A5;

  // Instance B: MEM_LAT=3
  logic        rst_b, rv_b, ren_b, val_b, rdy_b;
  logic [15:0] rpc_b, raddr_b, rdata_b, instr_b, pc_b;
  logic [2:0]  cnt_b;
  logic [15:0] mb [3];

  fetch_buffer #(.MEM_LAT(3), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_b), .redirect_valid(rv_b), .redirect_pc(rpc_b),
    .imem_raddr(raddr_b), .imem_ren(ren_b), .imem_rdata(rdata_b),
    .out_valid(val_b), .out_instr(instr_b), .out_pc(pc_b),
    .out_ready(rdy_b), .out_count(cnt_b)
  );

  always @(posedge clk) begin
    mb[0] <= raddr_b ^ 16'hA5A5;
    mb[1] <= mb[0];
    mb[2] <= mb[1];
  end
  assign rdata_b = mb[2];

  typedef struct {
    bit          rdy;
    bit          rv;
    logic [15:0] rpc;
    bit          ev;
    logic [15:0] epc;
    int          ecnt;
    bit          eren;
    logic [15:0] eaddr;
  } vec_t;

  vec_t tv [30];
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_b, iss_b;
  int out_b, deliv_b;

  function automatic vec_t mk(bit rdy, bit rv, logic [15:0] rpc, bit ev,
                              logic [15:0] epc, int ecnt, bit eren, logic [15:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev;
    v.epc = epc; v.ecnt = ecnt; v.eren = eren; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_b(input int n);
    for (int c = 0; c < n; c++) begin
      rdy_b = c[0];
      #1;
      chk("b count bound", 32'(cnt_b <= 3'd4), 32'd1);
      chk("b outstanding bound", 32'(out_b <= 4), 32'd1);
      if (val_b && rdy_b) begin
        chk("b out_pc", 32'(pc_b), 32'(exp_b));
        chk("b out_instr", 32'(instr_b), 32'(exp_b ^ 16'hA5A5));
        exp_b = exp_b + 16'd2;
        deliv_b++;
        out_b--;
      end
      if (ren_b) begin
        chk("b raddr", 32'(raddr_b), 32'(iss_b));
        iss_b = iss_b + 16'd2;
        out_b++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Stream, redirect with arriving response + pop, back-to-back redirects, stall fill.
    tv[0]  = mk(1, 0, 16'h0,   0, 16'h0,   0, 1, 16'h0);
    tv[1]  = mk(1, 0, 16'h0,   0, 16'h0,   0, 1, 16'h2);
    tv[2]  = mk(1, 0, 16'h0,   1, 16'h0,   1, 1, 16'h4);
    tv[3]  = mk(1, 0, 16'h0,   1, 16'h2,   1, 1, 16'h6);
    tv[4]  = mk(1, 0, 16'h0,   1, 16'h4,   1, 1, 16'h8);
    tv[5]  = mk(1, 1, 16'h40,  1, 16'h6,   1, 0, 16'h0);
    tv[6]  = mk(1, 0, 16'h0,   0, 16'h0,   0, 1, 16'h40);
    tv[7]  = mk(1, 0, 16'h0,   0, 16'h0,   0, 1, 16'h42);
    tv[8]  = mk(1, 0, 16'h0,   1, 16'h40,  1, 1, 16'h44);
    tv[9]  = mk(1, 0, 16'h0,   1, 16'h42,  1, 1, 16'h46);
    tv[10] = mk(1, 1, 16'h100, 1, 16'h44,  1, 0, 16'h0);
    tv[11] = mk(1, 1, 16'h200, 0, 16'h0,   0, 0, 16'h0);
    tv[12] = mk(1, 0, 16'h0,   0, 16'h0,   0, 1, 16'h200);
    tv[13] = mk(1, 0, 16'h0,   0, 16'h0,   0, 1, 16'h202);
    tv[14] = mk(1, 0, 16'h0,   1, 16'h200, 1, 1, 16'h204);
    tv[15] = mk(0, 0, 16'h0,   1, 16'h202, 1, 1, 16'h206);
    tv[16] = mk(0, 0, 16'h0,   1, 16'h202, 2, 1, 16'h208);
    tv[17] = mk(0, 0, 16'h0,   1, 16'h202, 3, 0, 16'h0);
    for (int k = 18; k <= 24; k++) tv[k] = mk(0, 0, 16'h0, 1, 16'h202, 4, 0, 16'h0);
    tv[25] = mk(1, 0, 16'h0,   1, 16'h202, 4, 0, 16'h0);
    tv[26] = mk(1, 0, 16'h0,   1, 16'h204, 3, 1, 16'h20A);
    tv[27] = mk(1, 0, 16'h0,   1, 16'h206, 2, 1, 16'h20C);
    tv[28] = mk(1, 0, 16'h0,   1, 16'h208, 2, 1, 16'h20E);
    tv[29] = mk(1, 0, 16'h0,   1, 16'h20A, 2, 1, 16'h210);

    rst_a = 1'b1; rst_b = 1'b1;
    rv_a = 1'b0; rpc_a = '0; rdy_a = 1'b0;
    rv_b = 1'b0; rpc_b = '0; rdy_b = 1'b0;
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset out_valid", 32'(val_a), 32'd0);
    chk("reset out_count", 32'(cnt_a), 32'd0);
    chk("reset imem_ren",  32'(ren_a), 32'd0);
    chk("reset out_pc",    32'(pc_a), 32'd0);
    chk("reset out_instr", 32'(instr_a), 32'd0);
    chk("reset raddr",     32'(raddr_a), 32'd0);
    chk("reset b imem_ren", 32'(ren_b), 32'd0);

    @(posedge clk); #1;
    rst_a = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rdy_a = tv[i].rdy; rv_a = tv[i].rv; rpc_a = tv[i].rpc;
      #1;
      chk($sformatf("c%0d out_valid", i), 32'(val_a), 32'(tv[i].ev));
      chk($sformatf("c%0d out_count", i), 32'(cnt_a), 32'(tv[i].ecnt));
      chk($sformatf("c%0d imem_ren", i),  32'(ren_a), 32'(tv[i].eren));
      if (tv[i].eren) chk($sformatf("c%0d imem_raddr", i), 32'(raddr_a), 32'(tv[i].eaddr));
      if (tv[i].ev) begin
        chk($sformatf("c%0d out_pc", i),    32'(pc_a),    32'(tv[i].epc));
        chk($sformatf("c%0d out_instr", i), 32'(instr_a), 32'(tv[i].epc ^ 16'hA5A5));
      end
      @(posedge clk); #1;
    end
    rv_a = 1'b0; rdy_a = 1'b1;

    // MEM_LAT=3 stream with toggling ready, then asynchronous reset mid-stream.
    rst_b = 1'b1;
    exp_b = '0; iss_b = '0; out_b = 0; deliv_b = 0;
    run_b(40);
    chk("b delivered first run", 32'(deliv_b >= 15), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("b async reset out_valid", 32'(val_b), 32'd0);
    chk("b async reset out_count", 32'(cnt_b), 32'd0);
    chk("b async reset imem_ren",  32'(ren_b), 32'd0);
    chk("b async reset out_pc",    32'(pc_b), 32'd0);
    chk("b async reset raddr",     32'(raddr_b), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b1;
    exp_b = '0; iss_b = '0; out_b = 0; deliv_b = 0;
    run_b(30);
    chk("b delivered after reset", 32'(deliv_b >= 10), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
